// File: rtl/aftab_csr_pkg.sv
// Shared constants for the AFTAB machine-mode CSR bank.
// Operation encodings, default CSR indices and MSTATUS bit positions.
package aftab_csr_pkg;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    localparam int DEF_MSTATUS_IDX  = 16;
    localparam int DEF_MEPC_IDX     = 17;
    localparam int DEF_MCAUSE_IDX   = 18;
    localparam int DEF_MCYCLE_IDX   = 19;
    localparam int DEF_MCYCLEH_IDX  = 20;
    localparam int DEF_INT_MODE_BIT = 7;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    localparam logic [31:0] DEF_MSTATUS_WMASK = 32'h0000_1888;

endpackage

// File: rtl/aftab_csr_regfile_ext_if.sv
// CSR bank bus: operand path in, old-value read and trap/MRET status out.
// The datapath side is the master, the register bank is the slave.
interface aftab_csr_regfile_ext_if #(
    parameter int len    = 32,
    parameter int ADDR_W = 5
);

    logic [1:0]        csrOp;
    logic [ADDR_W-1:0] addressRegBank;
    logic [len-1:0]    inputRegBank;
    logic [len-1:0]    outRegBank;
    logic              trapEntry;
    logic [len-1:0]    trapMepc;
    logic [len-1:0]    trapMcause;
    logic              mretExec;
    logic              writeDropped;
    logic              MSTATUS_INT_MODE;
    logic              mieOut;
    logic [len-1:0]    mepcOut;

    modport master (
        output csrOp, addressRegBank, inputRegBank,
        output trapEntry, trapMepc, trapMcause, mretExec,
        input  outRegBank, writeDropped,
        input  MSTATUS_INT_MODE, mieOut, mepcOut
    );

    modport slave (
        input  csrOp, addressRegBank, inputRegBank,
        input  trapEntry, trapMepc, trapMcause, mretExec,
        output outRegBank, writeDropped,
        output MSTATUS_INT_MODE, mieOut, mepcOut
    );

endinterface

// File: rtl/aftab_csr_regfile_ext_counter.sv
// Free-running 2*len-bit cycle counter with independent half loads.
// A loaded half takes val_i; the other half keeps the incremented value.
module aftab_csr_counter #(
    parameter int len = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ldLo_i,
    input  logic           ldHi_i,
    input  logic [len-1:0] val_i,
    output logic [len-1:0] lo_o,
    output logic [len-1:0] hi_o
);

    logic [2*len-1:0] cnt_q;
    logic [2*len-1:0] cnt_d;
    logic [2*len-1:0] inc;

    assign inc = cnt_q + (2*len)'(1);

    always_comb begin
        cnt_d = inc;
        if (ldLo_i) cnt_d[len-1:0]     = val_i;
        if (ldHi_i) cnt_d[2*len-1:len] = val_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign lo_o = cnt_q[len-1:0];
    assign hi_o = cnt_q[2*len-1:len];

endmodule

// File: rtl/aftab_csr_regfile_ext.sv
// Machine-mode CSR bank: atomic write/set/clear with registered old-value
// read, trap-entry and MRET updates of MSTATUS/MEPC/MCAUSE, cycle counter.
module aftab_csr_regfile_ext
    import aftab_csr_pkg::*;
#(
    parameter int len          = 32,
    parameter int ADDR_W       = 5,
    parameter int MSTATUS_IDX  = DEF_MSTATUS_IDX,
    parameter int MEPC_IDX     = DEF_MEPC_IDX,
    parameter int MCAUSE_IDX   = DEF_MCAUSE_IDX,
    parameter int MCYCLE_IDX   = DEF_MCYCLE_IDX,
    parameter int MCYCLEH_IDX  = DEF_MCYCLEH_IDX,
    parameter logic [len-1:0] MSTATUS_WMASK = len'(DEF_MSTATUS_WMASK),
    parameter int INT_MODE_BIT = DEF_INT_MODE_BIT
) (
    input logic clk,
    input logic rst,
    aftab_csr_regfile_ext_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;
    typedef logic [ADDR_W-1:0] idx_t;

    localparam idx_t A_MST  = idx_t'(MSTATUS_IDX);
    localparam idx_t A_MEPC = idx_t'(MEPC_IDX);
    localparam idx_t A_MCS  = idx_t'(MCAUSE_IDX);
    localparam idx_t A_CYC  = idx_t'(MCYCLE_IDX);
    localparam idx_t A_CYCH = idx_t'(MCYCLEH_IDX);

    logic [len-1:0] regs_q [DEPTH];
    logic [len-1:0] regs_d [DEPTH];
    logic [len-1:0] out_q;
    logic           wd_q;

    logic [len-1:0] rdVal;
    logic [len-1:0] newVal;
    logic [len-1:0] cntLo;
    logic [len-1:0] cntHi;
    logic           swWe;
    logic           ldLo;
    logic           ldHi;
    csr_op_e        op;
    idx_t           addr;

    assign op   = csr_op_e'(bus.csrOp);
    assign addr = bus.addressRegBank;

    always_comb begin
        rdVal = regs_q[addr];
        if (addr == '0)         rdVal = '0;
        else if (addr == A_CYC)  rdVal = cntLo;
        else if (addr == A_CYCH) rdVal = cntHi;
    end

    // set/clear with a zero operand is treated as no write at all
    always_comb begin
        newVal = bus.inputRegBank;
        swWe   = 1'b0;
        unique case (op)
            CSR_NONE:  swWe = 1'b0;
            CSR_WRITE: swWe = 1'b1;
            CSR_SET: begin
                newVal = rdVal | bus.inputRegBank;
                swWe   = |bus.inputRegBank;
            end
            CSR_CLEAR: begin
                newVal = rdVal & ~bus.inputRegBank;
                swWe   = |bus.inputRegBank;
            end
        endcase
        if (bus.trapEntry || addr == '0) swWe = 1'b0;
    end

    assign ldLo = swWe && (addr == A_CYC);
    assign ldHi = swWe && (addr == A_CYCH);

    always_comb begin
        regs_d = regs_q;
        if (swWe && !ldLo && !ldHi)
            regs_d[addr] = (addr == A_MST) ? (newVal & MSTATUS_WMASK)
                                           : newVal;
        if (bus.trapEntry) begin
            regs_d[A_MEPC]           = bus.trapMepc;
            regs_d[A_MCS]            = bus.trapMcause;
            regs_d[A_MST][MPIE_BIT]  = regs_q[A_MST][MIE_BIT];
            regs_d[A_MST][MIE_BIT]   = 1'b0;
        end else if (bus.mretExec) begin
            regs_d[A_MST][MIE_BIT]   = regs_q[A_MST][MPIE_BIT];
            regs_d[A_MST][MPIE_BIT]  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            out_q <= '0;
            wd_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            out_q  <= rdVal;
            wd_q   <= bus.trapEntry && (op != CSR_NONE);
        end
    end

    aftab_csr_counter #(.len(len)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .ldLo_i (ldLo),
        .ldHi_i (ldHi),
        .val_i  (newVal),
        .lo_o   (cntLo),
        .hi_o   (cntHi)
    );

    assign bus.outRegBank       = out_q;
    assign bus.writeDropped     = wd_q;
    assign bus.MSTATUS_INT_MODE = regs_q[A_MST][INT_MODE_BIT];
    assign bus.mieOut           = regs_q[A_MST][MIE_BIT];
    assign bus.mepcOut          = regs_q[A_MEPC];

endmodule

// File: tb/tb_aftab_csr_regfile_ext.sv
// Bench for aftab_csr_regfile_ext: vector table fed through a scoreboard,
// plus a hand sequence for asynchronous reset after a trap.
module tb_aftab_csr_regfile_ext;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  addr;
        logic [31:0] din;
        logic        trap;
        logic        mret;
        logic [31:0] tm;
        logic [31:0] tc;
        logic        chk;
        logic [31:0] eout;
        logic        ewd;
        logic        emie;
        logic        eim;
        logic [31:0] emepc;
    } vec_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    vec_t tbl[$];
    vec_t sb[$];

    aftab_csr_regfile_ext_if #(.len(32), .ADDR_W(5)) bus ();

    aftab_csr_regfile_ext dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(logic [1:0] op, logic [4:0] a, logic [31:0] d,
                       logic tr, logic mr, logic [31:0] tm,
                       logic [31:0] tc, logic ck, logic [31:0] eo,
                       logic ew, logic em, logic ei, logic [31:0] ep);
        vec_t v;
        v.op = op; v.addr = a; v.din = d; v.trap = tr; v.mret = mr;
        v.tm = tm; v.tc = tc; v.chk = ck; v.eout = eo; v.ewd = ew;
        v.emie = em; v.eim = ei; v.emepc = ep;
        tbl.push_back(v);
    endtask

    task automatic drive_idle();
        bus.csrOp = 2'b00;
        bus.addressRegBank = '0;
        bus.inputRegBank = '0;
        bus.trapEntry = 1'b0;
        bus.trapMepc = '0;
        bus.trapMcause = '0;
        bus.mretExec = 1'b0;
    endtask

    task automatic run(vec_t v, int idx);
        vec_t e;
        @(negedge clk);
        bus.csrOp = v.op;
        bus.addressRegBank = v.addr;
        bus.inputRegBank = v.din;
        bus.trapEntry = v.trap;
        bus.mretExec = v.mret;
        bus.trapMepc = v.tm;
        bus.trapMcause = v.tc;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk)
            check($sformatf("v%0d out", idx), bus.outRegBank, e.eout);
        check($sformatf("v%0d wd", idx), 32'(bus.writeDropped), 32'(e.ewd));
        check($sformatf("v%0d mie", idx), 32'(bus.mieOut), 32'(e.emie));
        check($sformatf("v%0d intmode", idx),
              32'(bus.MSTATUS_INT_MODE), 32'(e.eim));
        check($sformatf("v%0d mepc", idx), bus.mepcOut, e.emepc);
    endtask

    task automatic check_zero(string tag);
        check({tag, " out"}, bus.outRegBank, 32'h0);
        check({tag, " wd"}, 32'(bus.writeDropped), 32'h0);
        check({tag, " mie"}, 32'(bus.mieOut), 32'h0);
        check({tag, " intmode"}, 32'(bus.MSTATUS_INT_MODE), 32'h0);
        check({tag, " mepc"}, bus.mepcOut, 32'h0);
    endtask

    initial begin
        vec_t v;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        drive_idle();

        // op addr din trap mret tm tc chk eout wd mie im mepc
        add(1, 5,  32'hDEADBEEF, 0,0, 0,0, 1, 32'h0,        0,0,0, 32'h0);
        add(0, 5,  32'h0,        0,0, 0,0, 1, 32'hDEADBEEF, 0,0,0, 32'h0);
        add(1, 0,  32'h1234,     0,0, 0,0, 1, 32'h0,        0,0,0, 32'h0);
        add(0, 0,  32'h0,        0,0, 0,0, 1, 32'h0,        0,0,0, 32'h0);
        add(1, 16, 32'h8,        0,0, 0,0, 1, 32'h0,        0,1,0, 32'h0);
        add(2, 16, 32'hFFFFFFFF, 0,0, 0,0, 1, 32'h8,        0,1,1, 32'h0);
        add(3, 16, 32'h8,        0,0, 0,0, 1, 32'h1888,     0,0,1, 32'h0);
        add(0, 16, 32'h0,        0,0, 0,0, 1, 32'h1880,     0,0,1, 32'h0);
        add(2, 16, 32'h0,        0,0, 0,0, 1, 32'h1880,     0,0,1, 32'h0);
        add(0, 16, 32'h0,        0,0, 0,0, 1, 32'h1880,     0,0,1, 32'h0);
        add(1, 16, 32'h8,        0,0, 0,0, 1, 32'h1880,     0,1,0, 32'h0);
        add(1, 5,  32'h55,       1,0, 32'h100, 32'h8000000B,
            1, 32'hDEADBEEF, 1,0,1, 32'h100);
        add(0, 5,  32'h0,        0,0, 0,0, 1, 32'hDEADBEEF, 0,0,1, 32'h100);
        add(0, 17, 32'h0,        0,0, 0,0, 1, 32'h100,      0,0,1, 32'h100);
        add(0, 18, 32'h0,        0,0, 0,0, 1, 32'h8000000B, 0,0,1, 32'h100);
        add(0, 16, 32'h0,        0,0, 0,0, 1, 32'h80,       0,0,1, 32'h100);
        add(0, 16, 32'h0,        0,1, 0,0, 1, 32'h80,       0,1,1, 32'h100);
        add(0, 16, 32'h0,        0,0, 0,0, 1, 32'h88,       0,1,1, 32'h100);
        add(1, 16, 32'h8,        0,0, 0,0, 1, 32'h88,       0,1,0, 32'h100);
        add(0, 16, 32'h0,        1,1, 32'h200, 32'h3,
            1, 32'h8, 0,0,1, 32'h200);
        add(0, 16, 32'h0,        0,0, 0,0, 1, 32'h80,       0,0,1, 32'h200);
        add(0, 18, 32'h0,        0,0, 0,0, 1, 32'h3,        0,0,1, 32'h200);
        add(1, 7,  32'hA5A5A5A5, 0,0, 0,0, 1, 32'h0,        0,0,1, 32'h200);
        add(3, 7,  32'h0000FFFF, 0,0, 0,0, 1, 32'hA5A5A5A5, 0,0,1, 32'h200);
        add(0, 7,  32'h0,        0,0, 0,0, 1, 32'hA5A50000, 0,0,1, 32'h200);
        add(1, 16, 32'hFFFFFFFF, 0,0, 0,0, 1, 32'h80,       0,1,1, 32'h200);
        add(0, 16, 32'h0,        0,0, 0,0, 1, 32'h1888,     0,1,1, 32'h200);
        // counter: low-half load with carry, then high-half load and wrap
        add(1, 19, 32'hFFFFFFFE, 0,0, 0,0, 0, 32'h0,        0,1,1, 32'h200);
        add(0, 19, 32'h0,        0,0, 0,0, 1, 32'hFFFFFFFE, 0,1,1, 32'h200);
        add(0, 19, 32'h0,        0,0, 0,0, 1, 32'hFFFFFFFF, 0,1,1, 32'h200);
        add(0, 19, 32'h0,        0,0, 0,0, 1, 32'h0,        0,1,1, 32'h200);
        add(0, 20, 32'h0,        0,0, 0,0, 1, 32'h1,        0,1,1, 32'h200);
        add(1, 19, 32'hFFFFFFFE, 0,0, 0,0, 1, 32'h2,        0,1,1, 32'h200);
        add(1, 20, 32'hFFFFFFFF, 0,0, 0,0, 1, 32'h1,        0,1,1, 32'h200);
        add(0, 19, 32'h0,        0,0, 0,0, 1, 32'hFFFFFFFF, 0,1,1, 32'h200);
        add(0, 20, 32'h0,        0,0, 0,0, 1, 32'h0,        0,1,1, 32'h200);
        add(0, 19, 32'h0,        0,0, 0,0, 1, 32'h1,        0,1,1, 32'h200);

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

        // trap, then asynchronous reset in the following cycle
        @(negedge clk);
        bus.csrOp = 2'b01;
        bus.addressRegBank = 5'd5;
        bus.inputRegBank = 32'h77;
        bus.trapEntry = 1'b1;
        bus.trapMepc = 32'h300;
        bus.trapMcause = 32'h5;
        @(posedge clk);
        #1;
        check("trap2 out", bus.outRegBank, 32'hDEADBEEF);
        check("trap2 wd", 32'(bus.writeDropped), 32'h1);
        check("trap2 mepc", bus.mepcOut, 32'h300);
        check("trap2 mie", 32'(bus.mieOut), 32'h0);
        #2;
        drive_idle();
        rst = 1'b1;
        #1;
        check_zero("async rst");
        @(negedge clk);
        rst = 1'b0;

        add(0, 17, 32'h0, 0,0, 0,0, 1, 32'h0, 0,0,0, 32'h0);
        add(0, 5,  32'h0, 0,0, 0,0, 1, 32'h0, 0,0,0, 32'h0);
        add(0, 16, 32'h0, 0,0, 0,0, 1, 32'h0, 0,0,0, 32'h0);
        for (int i = tbl.size() - 3; i < tbl.size(); i++) begin
            v = tbl[i];
            run(v, i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aftab_csr_regfile_ext.md
Name: aftab_csr_regfile_ext

Overview:
Parametrised machine-mode CSR register bank for the AFTAB interrupt datapath. It supports atomic CSR write/set/clear operations with a registered read of the old value. Hardware trap-entry and MRET updates of MSTATUS, MEPC and MCAUSE have fixed priority rules. It also holds a free-running 2*len-bit cycle counter mapped onto two CSR indices. It sits between the datapath CSR operand path and the interrupt controller.

Parameters:
len, 32, data width of every CSR entry
ADDR_W, 5, CSR index width; depth = 2**ADDR_W
MSTATUS_IDX, 16, index of MSTATUS
MEPC_IDX, 17, index of MEPC
MCAUSE_IDX, 18, index of MCAUSE
MCYCLE_IDX, 19, index of counter low half
MCYCLEH_IDX, 20, index of counter high half
MSTATUS_WMASK, 32'h0000_1888, software-writable bits of MSTATUS; other bits read 0
INT_MODE_BIT, 7, MSTATUS bit driven on MSTATUS_INT_MODE

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
csrOp  input  2  00 none, 01 write, 10 set (OR), 11 clear (AND-NOT)
addressRegBank  input  ADDR_W  CSR index
inputRegBank  input  len  operand
outRegBank  output  len  registered old value of addressed CSR
trapEntry  input  1  trap-entry pulse from the interrupt controller
trapMepc  input  len  PC saved on trap
trapMcause  input  len  cause code saved on trap
mretExec  input  1  MRET retire pulse
writeDropped  output  1  registered; software write suppressed by trapEntry
MSTATUS_INT_MODE  output  1  MSTATUS[INT_MODE_BIT]
mieOut  output  1  MSTATUS[3] (global interrupt enable)
mepcOut  output  len  current MEPC

Behaviour:
- One clock (clk); reset rst is asynchronous, active-high. On reset, all entries, the counter, outRegBank and writeDropped are 0.
- Read: every cycle, outRegBank <= value of entry[addressRegBank] before this cycle's update. Latency is 1 cycle, independent of csrOp.
- Index 0 reads 0 and ignores writes. Unmapped indices behave as plain len-bit storage.
- Software new value: write = in; set = old|in; clear = old&~in.
  - For MSTATUS the stored value is new & MSTATUS_WMASK.
  - Set or clear with in=0 leaves the entry unchanged.
- Trap entry (trapEntry=1):
  - MEPC <= trapMepc; MCAUSE <= trapMcause.
  - MSTATUS[7] <= MSTATUS[3]; MSTATUS[3] <= 0.
  - Any software write in the same cycle, to any index, is dropped, and writeDropped=1 in the next cycle.
- MRET (mretExec=1, trapEntry=0): MSTATUS[3] <= MSTATUS[7]; MSTATUS[7] <= 1. A software write to MSTATUS in the same cycle is applied first, then the MRET bit moves overwrite bits 3 and 7.
- trapEntry and mretExec both high: trap wins, MRET is ignored.
- Counter (2*len bits, C): increments by 1 every cycle; C = max wraps to 0.
  - A software write to MCYCLE_IDX replaces the low half with the new value. The high half takes the incremented value, including carry from the pre-write low half.
  - A write to MCYCLEH_IDX replaces the high half. The low half is incremented.
  - Set/clear on counter halves are computed from the pre-increment value.
  - Reads return the pre-increment value.
- MSTATUS_INT_MODE, mieOut and mepcOut are combinational from stored state. They reflect updates one cycle after the causing event.
- Reset asserted mid-operation clears everything immediately. No partial trap state survives.

Decomposition:
- Package aftab_csr_pkg holds:
  - csrOp encodings (CSR_NONE, CSR_WRITE, CSR_SET, CSR_CLEAR)
  - default CSR index constants
  - MSTATUS bit positions MIE=3, MPIE=7
  - default MSTATUS_WMASK
- Sub-module aftab_csr_counter: 2*len-bit up-counter with independent low/high half load and the carry rule above.

Test Plan:
- Reset, then csrOp=01 to addr 5 with 0xDEADBEEF, then read addr 5 -> outRegBank = 0 on the write cycle and 0xDEADBEEF on the following read; addr 0 written 0x1234 reads 0.
- MSTATUS holds 0x8; set with 0xFFFFFFFF -> reads 0x1888; clear with 0x8 -> reads 0x1880, mieOut=0, MSTATUS_INT_MODE=1.
- MSTATUS=0x8; trapEntry with trapMepc=0x100 and trapMcause=0x8000000B, while csrOp=01 writes addr 5 -> MEPC=0x100, MCAUSE=0x8000000B, MSTATUS=0x80, addr 5 unchanged, writeDropped=1 for one cycle.
- MSTATUS=0x80; mretExec -> MSTATUS=0x88. trapEntry and mretExec together from 0x8 -> MSTATUS=0x80.
- Write MCYCLE_IDX=0xFFFFFFFE with high half 0 -> after 2 cycles the low half reads 0 and the high half reads 1. Write MCYCLEH_IDX=0xFFFFFFFF with low half 0xFFFFFFFF -> the counter wraps to 0.
- Assert rst in the cycle after trapEntry -> all outputs 0 asynchronously. After release, MEPC=0 and mieOut=0.
